// File: rtl/cpu_run_ctrl.sv
// Run controller: program load from host, processor reset/run/halt and cycle count.
// Optional single-step support is enabled with `define RUN_CTRL_STEP_EN.
module cpu_run_ctrl #(
   parameter int AW = 8,
   parameter int IW = 12,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic          run_start,
   input  logic          halt_req,
   input  logic          host_valid,
   output logic          host_ready,
   input  logic [IW-1:0] host_data,
   input  logic          host_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_waddr,
   output logic [IW-1:0] imem_wdata,
   output logic          cpu_rst,
   output logic          cpu_ce,
   input  logic [AW-1:0] cpu_pc,
   output logic [2:0]    state,
   output logic          done,
`ifdef RUN_CTRL_STEP_EN
   input  logic          step_mode,
   input  logic          step,
`endif
   output logic [CW-1:0] cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_RUN    = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          cpu_rst_q, cpu_rst_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] pc_prev_q, pc_prev_d;
   logic          pc_valid_q, pc_valid_d;
   logic          gate;
   logic          halt_now;

`ifdef RUN_CTRL_STEP_EN
   assign gate = step_mode ? step : 1'b1;
`else
   assign gate = 1'b1;
`endif

   // Self-loop only counts on cycles that would actually execute.
   assign halt_now = halt_req |
                     (gate & pc_valid_q & (cpu_pc == pc_prev_q));

   assign state       = state_q;
   assign cpu_rst     = cpu_rst_q;
   assign cycle_count = cnt_q;
   assign imem_waddr  = waddr_q;
   assign imem_wdata  = host_data;

   always_comb begin
      state_d    = state_q;
      waddr_d    = waddr_q;
      cnt_d      = cnt_q;
      pc_prev_d  = pc_prev_q;
      pc_valid_d = pc_valid_q;
      host_ready = 1'b0;
      imem_we    = 1'b0;
      cpu_ce     = 1'b0;
      done       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d = S_LOAD;
               waddr_d = '0;
            end else if (run_start) begin
               state_d = S_START;
            end
         end
         S_LOAD: begin
            host_ready = 1'b1;
            if (host_valid) begin
               imem_we = 1'b1;
               waddr_d = waddr_q + AW'(1);
               if (host_last || (waddr_q == '1))
                  state_d = S_IDLE;
            end
         end
         S_START: begin
            cnt_d      = '0;
            pc_valid_d = 1'b0;
            state_d    = S_RUN;
         end
         S_RUN: begin
            cpu_ce = gate & ~halt_now;
            if (halt_now)
               state_d = S_HALTED;
            if (cpu_ce) begin
               pc_prev_d  = cpu_pc;
               pc_valid_d = 1'b1;
               if (cnt_q != '1)
                  cnt_d = cnt_q + CW'(1);
            end
         end
         S_HALTED: begin
            done = 1'b1;
            if (load_start) begin
               state_d = S_LOAD;
               waddr_d = '0;
            end else if (run_start) begin
               state_d = S_START;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Registered reset follows the state being entered.
      cpu_rst_d = !((state_d == S_RUN) || (state_d == S_HALTED));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cpu_rst_q  <= 1'b1;
         waddr_q    <= '0;
         cnt_q      <= '0;
         pc_prev_q  <= '0;
         pc_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpu_rst_q  <= cpu_rst_d;
         waddr_q    <= waddr_d;
         cnt_q      <= cnt_d;
         pc_prev_q  <= pc_prev_d;
         pc_valid_q <= pc_valid_d;
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: scoreboarded imem writes plus directed run/halt checks.
// Includes a small PC model standing in for the processor.
module tb_cpu_run_ctrl;
   localparam int AW = 8;
   localparam int IW = 12;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_start = 1'b0;
   logic          run_start = 1'b0;
   logic          halt_req = 1'b0;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic [IW-1:0] host_data = '0;
   logic          host_last = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [IW-1:0] imem_wdata;
   logic          cpu_rst;
   logic          cpu_ce;
   logic [AW-1:0] cpu_pc;
   logic [2:0]    state;
   logic          done;
   logic [CW-1:0] cycle_count;
`ifdef RUN_CTRL_STEP_EN
   logic          step_mode = 1'b0;
   logic          step = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   int ce_cnt = 0;
   logic loop_en = 1'b0;
   logic [AW+IW-1:0] sb_q[$];

   cpu_run_ctrl #(.AW(AW), .IW(IW), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .load_start(load_start), .run_start(run_start),
      .halt_req(halt_req),
      .host_valid(host_valid), .host_ready(host_ready),
      .host_data(host_data), .host_last(host_last),
      .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .cpu_pc(cpu_pc),
      .state(state), .done(done),
`ifdef RUN_CTRL_STEP_EN
      .step_mode(step_mode), .step(step),
`endif
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // Processor stand-in: PC advances on ce, optionally spinning at 7.
   always @(posedge clk) begin
      if (cpu_rst)
         cpu_pc <= '0;
      else if (cpu_ce)
         cpu_pc <= (loop_en && cpu_pc == 8'd7) ? 8'd7 : cpu_pc + 8'd1;
   end

   // Monitor: every imem write must match the oldest expected entry.
   always @(negedge clk) begin
      if (cpu_ce) ce_cnt++;
      if (imem_we) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL imem_write unexpected addr=%0d data=%h",
                     imem_waddr, imem_wdata);
         end else begin
            logic [AW+IW-1:0] e;
            e = sb_q.pop_front();
            if ({imem_waddr, imem_wdata} !== e) begin
               bad++;
               $display("FAIL imem_write got=%0d/%h exp=%0d/%h",
                        imem_waddr, imem_wdata, e[AW+IW-1:IW], e[IW-1:0]);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic push(input int a, input logic [IW-1:0] d);
      logic [AW-1:0] aa;
      aa = AW'(a);
      sb_q.push_back({aa, d});
   endtask

   task automatic start_run;
      run_start = 1'b1;
      tick;
      run_start = 1'b0;
      chk("start_state", state, 2);
      chk("start_cpu_rst", cpu_rst, 1);
      chk("start_ce", cpu_ce, 0);
      tick;
      chk("run_state", state, 3);
      chk("run_cpu_rst", cpu_rst, 0);
      chk("run_pc0", cpu_pc, 0);
   endtask

   initial begin
      logic [IW-1:0] d;
      int n;
      repeat (3) tick;
      chk("rst_state", state, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_count", cycle_count, 0);
      chk("rst_ready", host_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_ce", cpu_ce, 0);
      rst = 1'b0;
      tick;

      // 5 words, valid toggling, last on word 5
      load_start = 1'b1;
      tick;
      load_start = 1'b0;
      chk("load_state", state, 1);
      chk("load_ready", host_ready, 1);
      for (int i = 0; i < 5; i++) begin
         host_valid = 1'b0;
         tick;
         d = IW'(12'h100 + i * 3);
         host_valid = 1'b1;
         host_data = d;
         host_last = (i == 4);
         push(i, d);
         tick;
      end
      host_valid = 1'b0;
      host_last = 1'b0;
      chk("load5_idle", state, 0);
      chk("load5_sb_empty", sb_q.size(), 0);
      tick;

      // 256 words without last: stops at 255, no wrap
      load_start = 1'b1;
      tick;
      load_start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         d = IW'(i) ^ 12'hA5A;
         host_valid = 1'b1;
         host_data = d;
         push(i, d);
         tick;
      end
      chk("load256_idle", state, 0);
      chk("load256_ready", host_ready, 0);
      tick;
      chk("load256_ready2", host_ready, 0);
      chk("load256_we", imem_we, 0);
      chk("load256_sb_empty", sb_q.size(), 0);
      host_valid = 1'b0;

      // program spinning at address 7
      loop_en = 1'b1;
      start_run;
      n = 0;
      while (cpu_ce && n < 50) begin
         tick;
         n++;
      end
      chk("loop_seen", (n < 50), 1);
      chk("loop_pc", cpu_pc, 7);
      chk("loop_ce", cpu_ce, 0);
      tick;
      chk("loop_halted", state, 4);
      chk("loop_done", done, 1);
      chk("loop_count", cycle_count, 8);
      chk("loop_cpu_rst", cpu_rst, 0);
      tick;
      chk("loop_hold", cycle_count, 8);

      // halt request after 10 executed cycles, then restart
      loop_en = 1'b0;
      start_run;
      repeat (10) tick;
      chk("pre_halt_count", cycle_count, 10);
      halt_req = 1'b1;
      #1;
      chk("halt_ce", cpu_ce, 0);
      tick;
      halt_req = 1'b0;
      chk("halt_state", state, 4);
      chk("halt_count", cycle_count, 10);
      start_run;
      chk("restart_count", cycle_count, 0);

      // async reset mid-RUN
      repeat (3) tick;
      #2;
      rst = 1'b1;
      #1;
      chk("rstrun_state", state, 0);
      chk("rstrun_cpu_rst", cpu_rst, 1);
      chk("rstrun_count", cycle_count, 0);
      chk("rstrun_ce", cpu_ce, 0);
      tick;
      rst = 1'b0;
      tick;

      // async reset mid-LOAD
      load_start = 1'b1;
      tick;
      load_start = 1'b0;
      host_valid = 1'b1;
      host_data = 12'h3C3;
      push(0, 12'h3C3);
      tick;
      host_data = 12'h0F0;
      #1;
      rst = 1'b1;
      #1;
      chk("rstload_state", state, 0);
      chk("rstload_we", imem_we, 0);
      chk("rstload_cpu_rst", cpu_rst, 1);
      tick;
      host_valid = 1'b0;
      rst = 1'b0;
      tick;
      chk("rstload_sb_empty", sb_q.size(), 0);

`ifdef RUN_CTRL_STEP_EN
      // single-step: exactly 3 executed cycles
      step_mode = 1'b1;
      start_run;
      ce_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         repeat (2) tick;
         step = 1'b1;
         tick;
         step = 1'b0;
      end
      repeat (3) tick;
      chk("step_ce_cnt", ce_cnt, 3);
      chk("step_count", cycle_count, 3);
      chk("step_state", state, 3);
      halt_req = 1'b1;
      tick;
      halt_req = 1'b0;
      step_mode = 1'b0;
      chk("step_halted", state, 4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
